// File: rtl/cache_line_refill_pkg.sv
// Shared widths, line geometry and refill state encodings for the cache line refill engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_line_refill_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int WORD_WIDTH     = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int INDEX_WIDTH    = 4;
  localparam int PTR_WIDTH      = 2;
  localparam int LINE_BITS      = WORD_WIDTH * WORDS_PER_LINE;
  localparam int LINE_BYTES     = LINE_BITS / 8;
  localparam int TAG_WIDTH      = ADDR_WIDTH - 8;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [LINE_BITS-1:0]  line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refillState_t;

endpackage

// File: rtl/cache_line_refill_if.sv
// Bundles the miss, memory-read and RAM-write signals of the refill engine.
// Latency: n/a (wiring only).
// Backpressure: miss_ready / mem_gnt / mem_rvalid handshakes carried as plain signals.
interface cache_line_refill_if;
  import cache_line_refill_pkg::*;

  logic                    miss_req;
  logic [ADDR_WIDTH-1:0]   miss_addr;
  logic                    miss_ready;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  word_t                   mem_rdata;
  logic                    ram_wen;
  logic [INDEX_WIDTH-1:0]  ram_index;
  line_t                   ram_data;
  logic [LINE_BYTES-1:0]   ram_strb;
  logic                    tag_wen;
  logic [TAG_WIDTH-1:0]    tag_out;
  logic                    crit_valid;
  word_t                   crit_data;
  logic                    refill_done;

  // Refill engine side.
  modport master (
    input  miss_req, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    output miss_ready, mem_req, mem_addr, ram_wen, ram_index, ram_data, ram_strb,
           tag_wen, tag_out, crit_valid, crit_data, refill_done
  );

  // Cache controller / memory / RAM side.
  modport slave (
    output miss_req, miss_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  miss_ready, mem_req, mem_addr, ram_wen, ram_index, ram_data, ram_strb,
           tag_wen, tag_out, crit_valid, crit_data, refill_done
  );

endinterface

// File: rtl/refill_line_buffer.sv
// Four-word line buffer with wrapping slot pointer and beat counter for one refill.
// Latency: beat stored on the capture edge; lineNext/fillDone/critHit are same-cycle decodes.
// Backpressure: none; advances only when capture is asserted, so gaps simply stall it.
module refill_line_buffer
  import cache_line_refill_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PTR_WIDTH-1:0] startPtr,
  input  logic                 capture,
  input  word_t                beatData,
  input  logic [PTR_WIDTH-1:0] critSlot,
  output logic                 critHit,
  output logic                 fillDone,
  output line_t                lineNext
);

  word_t                words [WORDS_PER_LINE];
  logic [PTR_WIDTH-1:0] ptr;
  logic [PTR_WIDTH-1:0] beatCnt;

  // Start seeds the slot pointer and clears the count; each captured beat fills slot ptr and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        words[i] <= '0;
      end
      ptr     <= '0;
      beatCnt <= '0;
    end else if (start) begin
      ptr     <= startPtr;
      beatCnt <= '0;
    end else if (capture) begin
      words[ptr] <= beatData;
      ptr        <= ptr + 2'd1;
      beatCnt    <= beatCnt + 2'd1;
    end
  end

  // Merge the beat being captured so the full line is ready on the edge that ends FILL.
  always_comb begin
    lineNext = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      lineNext[i*WORD_WIDTH +: WORD_WIDTH] = (capture && ptr == 2'(i)) ? beatData : words[i];
    end
  end

  assign critHit  = capture && (ptr == critSlot);
  assign fillDone = capture && (beatCnt == 2'd3);

endmodule

// File: rtl/cache_line_refill.sv
// Cache line refill: on a miss issues one 4-beat read burst and writes the assembled line plus tag.
// Latency: miss accepted cycle 0, mem_req cycle 1, line write earliest cycle 6, ready again cycle 7.
// Backpressure: miss_ready low while busy; mem_req held until mem_gnt; beat gaps stall FILL forever.
// Build option CACHE_REFILL_CWF_EN: burst starts at the missed word (critical word first).
module cache_line_refill
  import cache_line_refill_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cache_line_refill_if.master bus
);

  refillState_t            state;
  refillState_t            stateNext;
  logic [ADDR_WIDTH-1:2]   addrQ;
  line_t                   ramDataQ;
  logic [INDEX_WIDTH-1:0]  indexQ;
  logic [TAG_WIDTH-1:0]    tagQ;
  logic                    critValidQ;
  word_t                   critDataQ;
  logic                    start;
  logic                    capture;
  logic                    critHit;
  logic                    fillDone;
  line_t                   lineNext;
  logic [PTR_WIDTH-1:0]    startPtr;
  logic                    unusedByteOffset;

  // Byte offset within a word never matters to a line refill.
  assign unusedByteOffset = ^bus.miss_addr[1:0];

  assign start   = (state == REQ) && bus.mem_gnt;
  assign capture = (state == FILL) && bus.mem_rvalid;

`ifdef CACHE_REFILL_CWF_EN
  assign startPtr     = addrQ[3:2];
  assign bus.mem_addr = {addrQ, 2'b00};
`else
  assign startPtr     = '0;
  assign bus.mem_addr = {addrQ[ADDR_WIDTH-1:4], 4'b0000};
`endif

  refill_line_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .startPtr (startPtr),
    .capture  (capture),
    .beatData (bus.mem_rdata),
    .critSlot (addrQ[3:2]),
    .critHit  (critHit),
    .fillDone (fillDone),
    .lineNext (lineNext)
  );

  // State register; reset drops any partial refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state: accept miss, wait for grant, collect four beats, one write cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.miss_req) stateNext = REQ;
      REQ:     if (bus.mem_gnt)  stateNext = FILL;
      FILL:    if (fillDone)     stateNext = WRITE;
      WRITE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Control outputs decoded purely from the registered state.
  always_comb begin
    bus.miss_ready  = 1'b0;
    bus.mem_req     = 1'b0;
    bus.ram_wen     = 1'b0;
    bus.tag_wen     = 1'b0;
    bus.refill_done = 1'b0;
    bus.ram_strb    = '0;
    case (state)
      IDLE: bus.miss_ready = 1'b1;
      REQ:  bus.mem_req    = 1'b1;
      WRITE: begin
        bus.ram_wen     = 1'b1;
        bus.tag_wen     = 1'b1;
        bus.refill_done = 1'b1;
        bus.ram_strb    = '1;
      end
      default: ;
    endcase
  end

  // Latch the miss address only when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          addrQ <= '0;
    else if (state == IDLE && bus.miss_req) addrQ <= bus.miss_addr[ADDR_WIDTH-1:2];
  end

  // Write-port data, index and tag load together as FILL completes and hold until the next line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ramDataQ <= '0;
      indexQ   <= '0;
      tagQ     <= '0;
    end else if (fillDone) begin
      ramDataQ <= lineNext;
      indexQ   <= addrQ[7:4];
      tagQ     <= addrQ[ADDR_WIDTH-1:8];
    end
  end

  // Registered one-cycle pulse for the requested word, keeping inputs off the output paths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      critValidQ <= 1'b0;
      critDataQ  <= '0;
    end else begin
      critValidQ <= critHit;
      if (critHit) critDataQ <= bus.mem_rdata;
    end
  end

  assign bus.ram_data   = ramDataQ;
  assign bus.ram_index  = indexQ;
  assign bus.tag_out    = tagQ;
  assign bus.crit_valid = critValidQ;
  assign bus.crit_data  = critDataQ;

endmodule

// File: tb/tb_cache_line_refill.sv
// Bench for cache_line_refill: transaction-level model plus per-cycle output comparison.
// Directed cases pin literal line/address/crit values; random refills cover stalls and spurious beats.
// Honours CACHE_REFILL_CWF_EN for burst ordering expectations.
`timescale 1ns/1ps
module tb_cache_line_refill;
  import cache_line_refill_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_line_refill_if bus();

  cache_line_refill dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef CACHE_REFILL_CWF_EN
  localparam logic [31:0]  A1234_MEMADDR  = 32'h0000_1234;
  localparam logic [127:0] A1234_LINE     = 128'h33333333_22222222_11111111_44444444;
  localparam int           A1234_CRITBEAT = 1;
  localparam logic [31:0]  A1234_CRITDATA = 32'h11111111;
  localparam logic [31:0]  AAC_MEMADDR    = 32'h0000_00AC;
  localparam logic [127:0] AAC_LINE       = 128'h0000000A_0000000D_0000000C_0000000B;
  localparam int           AAC_CRITBEAT   = 1;
  localparam logic [31:0]  AAC_CRITDATA   = 32'h0000000A;
  localparam logic [31:0]  HOLD2_MEMADDR  = 32'h0000_9AB4;
`else
  localparam logic [31:0]  A1234_MEMADDR  = 32'h0000_1230;
  localparam logic [127:0] A1234_LINE     = 128'h44444444_33333333_22222222_11111111;
  localparam int           A1234_CRITBEAT = 2;
  localparam logic [31:0]  A1234_CRITDATA = 32'h22222222;
  localparam logic [31:0]  AAC_MEMADDR    = 32'h0000_00A0;
  localparam logic [127:0] AAC_LINE       = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam int           AAC_CRITBEAT   = 4;
  localparam logic [31:0]  AAC_CRITDATA   = 32'h0000000D;
  localparam logic [31:0]  HOLD2_MEMADDR  = 32'h0000_9AB0;
`endif
  localparam logic [127:0] BEATS_1234 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] BEATS_ABCD = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic         mBusy, mGranted, mWrite, mCrit;
  int           mBeats;
  logic [31:0]  mAddr, mCritData;
  logic [31:0]  mLine [4];
  logic [127:0] mLastLine;

  function automatic int startSlot(input logic [31:0] a);
`ifdef CACHE_REFILL_CWF_EN
    return int'(a[3:2]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] expMemAddr(input logic [31:0] a);
`ifdef CACHE_REFILL_CWF_EN
    return {a[31:2], 2'b00};
`else
    return {a[31:4], 4'b0000};
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mBusy = 0; mGranted = 0; mWrite = 0; mCrit = 0; mBeats = 0;
      mAddr = 0; mCritData = 0; mLastLine = 0;
    end else begin
      mCrit = 0;
      if (mWrite) begin
        mWrite = 0;
        mBusy  = 0;
      end else if (!mBusy) begin
        if (bus.miss_req) begin
          mBusy = 1; mGranted = 0; mBeats = 0; mAddr = bus.miss_addr;
        end
      end else if (!mGranted) begin
        mGranted = bus.mem_gnt;
      end else if (bus.mem_rvalid) begin
        int slot;
        slot = (startSlot(mAddr) + mBeats) % 4;
        mLine[slot] = bus.mem_rdata;
        if (slot == int'(mAddr[3:2])) begin
          mCrit = 1;
          mCritData = bus.mem_rdata;
        end
        mBeats++;
        if (mBeats == 4) begin
          mWrite = 1;
          mLastLine = {mLine[3], mLine[2], mLine[1], mLine[0]};
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmpOn = 0;
  always @(negedge clk) begin
    if (cmpOn) begin
      chk("miss_ready", bus.miss_ready, !mBusy);
      chk("mem_req", bus.mem_req, mBusy && !mGranted);
      if (mBusy && !mGranted) chk("mem_addr", bus.mem_addr, expMemAddr(mAddr));
      chk("ram_wen", bus.ram_wen, mWrite);
      chk("tag_wen", bus.tag_wen, mWrite);
      chk("refill_done", bus.refill_done, mWrite);
      chk("ram_strb", bus.ram_strb, mWrite ? 16'hFFFF : 16'h0000);
      chk("crit_valid", bus.crit_valid, mCrit);
      if (mCrit) chk("crit_data", bus.crit_data, mCritData);
      if (mWrite) begin
        chk("ram_data", bus.ram_data, mLastLine);
        chk("ram_index", bus.ram_index, mAddr[7:4]);
        chk("tag_out", bus.tag_out, mAddr[31:8]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int           cyc, beatsSent, obsCritBeat, obsWenCycle, obsDone;
  logic [31:0]  obsMemAddr, obsCritData;
  logic [127:0] obsLine;
  logic [3:0]   obsIndex;
  logic [23:0]  obsTag;

  task automatic stepClk();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.crit_valid) begin
      obsCritBeat = beatsSent;
      obsCritData = bus.crit_data;
    end
    if (bus.ram_wen) begin
      obsWenCycle = cyc;
      obsLine     = bus.ram_data;
      obsIndex    = bus.ram_index;
      obsTag      = bus.tag_out;
    end
    if (bus.refill_done) obsDone++;
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, " miss_ready"}, bus.miss_ready, 1'b1);
    chk({tag, " mem_req"}, bus.mem_req, 1'b0);
    chk({tag, " mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, " ram_wen"}, bus.ram_wen, 1'b0);
    chk({tag, " ram_index"}, bus.ram_index, 4'h0);
    chk({tag, " ram_data"}, bus.ram_data, 128'h0);
    chk({tag, " ram_strb"}, bus.ram_strb, 16'h0);
    chk({tag, " tag_wen"}, bus.tag_wen, 1'b0);
    chk({tag, " tag_out"}, bus.tag_out, 24'h0);
    chk({tag, " crit_valid"}, bus.crit_valid, 1'b0);
    chk({tag, " crit_data"}, bus.crit_data, 32'h0);
    chk({tag, " refill_done"}, bus.refill_done, 1'b0);
  endtask

  // One refill: optional grant delay, beat gaps, spurious beats, held miss_req, or reset after N beats.
  task automatic doRefill(input logic [31:0] addr, input logic [127:0] beats, input int gntDelay,
                          input int gapLo, input int gapHi, input bit spurious, input bit holdReq,
                          input int abortAfter);
    int waitCnt = 0;
    obsCritBeat = 0; obsWenCycle = 0; obsDone = 0; beatsSent = 0;
    obsMemAddr = 0; obsCritData = 0; obsLine = 0; obsIndex = 0; obsTag = 0;
    while (!bus.miss_ready && waitCnt < 20) begin
      stepClk();
      waitCnt++;
    end
    chk("miss_ready before request", bus.miss_ready, 1'b1);
    cyc = 0;
    bus.miss_req  = 1'b1;
    bus.miss_addr = addr;
    if (spurious) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
    end
    stepClk();
    obsMemAddr = bus.mem_addr;
    chk("request accepted", bus.miss_ready, 1'b0);
    bus.mem_rvalid = 1'b0;
    if (holdReq) bus.miss_addr = $urandom;
    else         bus.miss_req  = 1'b0;
    for (int i = 0; i < gntDelay; i++) stepClk();
    bus.mem_gnt = 1'b1;
    if (spurious) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
    end
    stepClk();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == abortAfter) begin
        bus.miss_req = 1'b0;
        rst = 1'b0;
        #1;
        chkResetOutputs("abort");
        stepClk();
        stepClk();
        rst = 1'b1;
        stepClk();
        return;
      end
      repeat ($urandom_range(gapHi, gapLo)) stepClk();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beats[32*i +: 32];
      beatsSent      = i + 1;
      if (holdReq && i == 1) bus.miss_addr = $urandom;
      stepClk();
      bus.mem_rvalid = 1'b0;
    end
    stepClk();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.miss_req = 0; bus.miss_addr = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chkResetOutputs("reset");
    cmpOn = 1;
    rst = 1'b1;
    stepClk();

    // Minimum-latency refill of 0x1234.
    doRefill(32'h0000_1234, BEATS_1234, 0, 0, 0, 0, 0, 99);
    chk("1234 mem_addr", obsMemAddr, A1234_MEMADDR);
    chk("1234 ram_data", obsLine, A1234_LINE);
    chk("1234 model line", mLastLine, A1234_LINE);
    chk("1234 ram_index", obsIndex, 4'h3);
    chk("1234 tag_out", obsTag, 24'h000012);
    chk("1234 crit beat", obsCritBeat, A1234_CRITBEAT);
    chk("1234 crit_data", obsCritData, A1234_CRITDATA);
    chk("1234 ram_wen cycle", obsWenCycle, 6);
    chk("1234 ready at cycle 7", bus.miss_ready, 1'b1);

    // Miss on word 3 of line 0xA.
    doRefill(32'h0000_00AC, BEATS_ABCD, 0, 0, 0, 0, 0, 99);
    chk("00AC mem_addr", obsMemAddr, AAC_MEMADDR);
    chk("00AC ram_data", obsLine, AAC_LINE);
    chk("00AC ram_index", obsIndex, 4'hA);
    chk("00AC crit beat", obsCritBeat, AAC_CRITBEAT);
    chk("00AC crit_data", obsCritData, AAC_CRITDATA);

    // Grant after 5 cycles, one idle cycle between beats, spurious beats in IDLE and grant cycle.
    doRefill(32'h0000_1234, BEATS_1234, 5, 1, 1, 1, 0, 99);
    chk("stall ram_data", obsLine, A1234_LINE);
    chk("stall done once", obsDone, 1);

    // Reset after two beats: no write, then a clean refill.
    doRefill(32'h0000_00AC, BEATS_ABCD, 0, 0, 0, 0, 0, 2);
    chk("abort no ram_wen", obsWenCycle, 0);
    chk("abort no done", obsDone, 0);
    doRefill(32'h0000_1234, BEATS_1234, 0, 0, 0, 0, 0, 99);
    chk("post-abort ram_data", obsLine, A1234_LINE);
    chk("post-abort done once", obsDone, 1);

    // miss_req held across a refill with a changing address; next request taken immediately.
    doRefill(32'h0000_5670, BEATS_ABCD, 0, 0, 1, 0, 1, 99);
    chk("hold tag_out", obsTag, 24'h000056);
    chk("hold ram_index", obsIndex, 4'h7);
    doRefill(32'h0000_9AB4, BEATS_1234, 1, 0, 1, 0, 0, 99);
    chk("hold next mem_addr", obsMemAddr, HOLD2_MEMADDR);
    chk("hold next tag_out", obsTag, 24'h00009A);

    // Random refills.
    for (int n = 0; n < 20; n++) begin
      logic [127:0] rb;
      rb = {$urandom, $urandom, $urandom, $urandom};
      doRefill($urandom, rb, $urandom_range(3, 0), 0, 2, 1'($urandom_range(1, 0)),
               (n < 19) ? 1'($urandom_range(1, 0)) : 1'b0, 99);
      chk("random line vs model", obsLine, mLastLine);
      chk("random done once", obsDone, 1);
    end
    bus.miss_req = 1'b0;
    stepClk();
    stepClk();

    cmpOn = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
